// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control and hazard unit for the in-order MIPS pipe.
//   - Per-operand forwarding select from FWD_DEPTH producer stages (stage 2+k).
//   - Load-use detection for producers younger than LOAD_STAGE.
//   - Multi-cycle EXE sequencing (IDLE/BUSY counter FSM).
//   - Per-stage enable / bubble vectors, redirect squash, debug single-step.
//   - Saturating count of stalled cycles.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   debug_en, debug_step    freeze pipe; rising edge of step releases one cycle
//   id_rs/rt_addr, _used    ID operand addresses and use flags
//   id_redirect             ID holds a taken branch/jump
//   exe_is_md               EXE holds a multi-cycle op
//   prod_wen/is_load/waddr  producer k info (waddr flattened, k=0 in LSBs)
//   stage_en, stage_rst     per-stage enable and bubble/flush
//   fwd_a, fwd_b            0 = register file, k+1 = producer k
//   load_stall, md_stall    hazard flags
//   md_busy                 FSM in BUSY
//   stall_cnt               saturating stall-cycle count

// Per-operand forwarding select: youngest matching producer wins.
module phc_fwd_sel #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 1,
    parameter int FWD_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]                 addr,
    input  logic                                  used,
    input  logic [FWD_DEPTH-1:0]                  prod_wen,
    input  logic [FWD_DEPTH-1:0]                  prod_is_load,
    input  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0]  prod_waddr,
    output logic [FWD_W-1:0]                      fwd,
    output logic                                  hazard
);
    logic found;

    always_comb begin
        fwd    = '0;
        hazard = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (!found && used && (addr != '0) && prod_wen[k] && (prod_waddr[k] == addr)) begin
                found = 1'b1;
                // Load data not yet available this close to ID: stall instead.
                if (prod_is_load[k] && (k < LOAD_STAGE))
                    hazard = 1'b1;
                else
                    fwd = FWD_W'(k + 1);
            end
        end
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 1,
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 16,
    parameter int FWD_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            debug_en,
    input  logic                            debug_step,
    input  logic [REG_ADDR_W-1:0]           id_rs_addr,
    input  logic [REG_ADDR_W-1:0]           id_rt_addr,
    input  logic                            id_rs_used,
    input  logic                            id_rt_used,
    input  logic                            id_redirect,
    input  logic                            exe_is_md,
    input  logic [FWD_DEPTH-1:0]            prod_wen,
    input  logic [FWD_DEPTH-1:0]            prod_is_load,
    input  logic [FWD_DEPTH*REG_ADDR_W-1:0] prod_waddr,
    output logic [NUM_STAGES-1:0]           stage_en,
    output logic [NUM_STAGES-1:0]           stage_rst,
    output logic [FWD_W-1:0]                fwd_a,
    output logic [FWD_W-1:0]                fwd_b,
    output logic                            load_stall,
    output logic                            md_stall,
    output logic                            md_busy,
    output logic [CNT_W-1:0]                stall_cnt
);
    localparam int MD_CW   = $clog2(MD_LATENCY + 1);
    localparam int MD_LOAD = (MD_LATENCY > 1) ? MD_LATENCY - 2 : 0;

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t                                  state, nxt_state;
    logic [MD_CW-1:0]                           cnt, nxt_cnt;
    logic                                       step_prev;
    logic                                       frozen;
    logic                                       md_stall_raw;
    logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0]       waddr_v;
    logic [1:0][REG_ADDR_W-1:0]                 op_addr;
    logic [1:0]                                 op_used;
    logic [1:0][FWD_W-1:0]                      op_fwd;
    logic [1:0]                                 op_haz;

    assign waddr_v = prod_waddr;
    assign op_addr = {id_rt_addr, id_rs_addr};
    assign op_used = {id_rt_used, id_rs_used};

    // Operand 0 = RS, operand 1 = RT.
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_op
            phc_fwd_sel #(
                .REG_ADDR_W (REG_ADDR_W),
                .FWD_DEPTH  (FWD_DEPTH),
                .LOAD_STAGE (LOAD_STAGE),
                .FWD_W      (FWD_W)
            ) u_sel (
                .addr         (op_addr[g]),
                .used         (op_used[g]),
                .prod_wen     (prod_wen),
                .prod_is_load (prod_is_load),
                .prod_waddr   (waddr_v),
                .fwd          (op_fwd[g]),
                .hazard       (op_haz[g])
            );
        end
    endgenerate

    // Outputs are combinational, so reset values are forced here directly.
    assign fwd_a      = rst_n ? op_fwd[0] : '0;
    assign fwd_b      = rst_n ? op_fwd[1] : '0;
    assign load_stall = rst_n & (|op_haz);
    assign md_stall   = rst_n & md_stall_raw;
    assign md_busy    = (state == BUSY);

    // Frozen unless this cycle carries a fresh rising edge of debug_step.
    assign frozen = debug_en && !(debug_step && !step_prev);

    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        md_stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (exe_is_md && (MD_LATENCY > 1)) begin
                    md_stall_raw = 1'b1;
                    nxt_cnt      = MD_CW'(MD_LOAD);
                    nxt_state    = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    md_stall_raw = 1'b1;
                    nxt_cnt      = cnt - MD_CW'(1);
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (frozen) begin
            nxt_state = state;
            nxt_cnt   = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            step_prev <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            step_prev <= debug_step;
            if (!frozen && (md_stall || load_stall) && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Stage control. md_stall outranks load_stall; any stall holds ID, so
    // the redirect flush waits until ID re-presents it.
    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        if (!rst_n) begin
            stage_rst = '1;
        end else if (frozen) begin
            stage_en = '0;
        end else if (md_stall) begin
            stage_en[2:0] = '0;
            stage_rst[3]  = 1'b1;
        end else if (load_stall) begin
            stage_en[1:0] = '0;
            stage_rst[2]  = 1'b1;
        end else if (id_redirect) begin
            stage_rst[0] = 1'b1;
        end
    end
endmodule
